// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the LSU memory controller: bus widths, active-low
// strobe levels, access-size and FSM state encodings.
package lsu_mem_ctrl_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  // Memory strobes are active low
  localparam logic WriteEnable  = 1'b0;
  localparam logic WriteDisable = 1'b1;
  localparam logic ReadEnable   = 1'b0;
  localparam logic ReadDisable  = 1'b1;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_R = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

  function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return lo[0];
      SIZE_W:  return |lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational load extract/extend and store byte-lane merge; also used by
// the core's forwarding path.
module lsu_align
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int DW = RegBus
) (
  input  size_e          size_i,
  input  logic           unsigned_i,
  input  logic [1:0]     lane_i,
  input  logic [DW-1:0]  rword_i,
  input  logic [DW-1:0]  wdata_i,
  output logic [DW-1:0]  ldata_o,
  output logic [DW-1:0]  wword_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rword_i[{lane_i, 3'b000} +: 8];
  assign half_v = rword_i[{lane_i[1], 4'b0000} +: 16];

  always_comb begin
    ldata_o = rword_i;
    wword_o = wdata_i;
    case (size_i)
      SIZE_B: begin
        ldata_o = unsigned_i ? {{(DW-8){1'b0}}, byte_v} : {{(DW-8){byte_v[7]}}, byte_v};
        wword_o = rword_i;
        wword_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SIZE_H: begin
        ldata_o = unsigned_i ? {{(DW-16){1'b0}}, half_v} : {{(DW-16){half_v[15]}}, half_v};
        wword_o = rword_i;
        wword_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: turns one byte-addressed core request at a time into
// word reads/writes on the data memory, with read-modify-write for sub-words.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int MEM_AW = RegAddrBus,
  parameter int DW     = RegBus
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DW-1:0]     req_wdata,
  output logic              resp_valid,
  output logic [DW-1:0]     resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_din,
  input  logic [DW-1:0]     mem_dout,
  output logic              mem_WRn,
  output logic              mem_RDn
);

  state_e            state_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic [DW-1:0]     resp_rdata_q;
  logic              resp_err_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [DW-1:0]     mem_din_q;
  logic              mem_WRn_q;
  logic              mem_RDn_q;
  logic              we_q;
  size_e             size_q;
  logic              uns_q;
  logic [1:0]        lane_q;
  logic [DW-1:0]     wdata_q;

  logic [DW-1:0]     ld_data;
  logic [DW-1:0]     st_word;
  logic              req_misaligned;
  logic              unused_addr_hi;

  // Upper address bits are deliberately dropped: accesses wrap
  assign unused_addr_hi = ^req_addr[31:MEM_AW+2];
  assign req_misaligned = is_misaligned(size_e'(req_size), req_addr[1:0]);

  lsu_align #(.DW(DW)) u_align (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .lane_i     (lane_q),
    .rword_i    (mem_dout),
    .wdata_i    (wdata_q),
    .ldata_o    (ld_data),
    .wword_o    (st_word)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_WRn_q    <= WriteDisable;
      mem_RDn_q    <= ReadDisable;
      we_q         <= 1'b0;
      size_q       <= SIZE_B;
      uns_q        <= 1'b0;
      lane_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            size_q      <= size_e'(req_size);
            uns_q       <= req_unsigned;
            lane_q      <= req_addr[1:0];
            wdata_q     <= req_wdata;
            mem_addr_q  <= req_addr[MEM_AW+1:2];
            req_ready_q <= 1'b0;
            if (req_misaligned) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (req_we && size_e'(req_size) == SIZE_W) begin
              state_q   <= WR;
              mem_WRn_q <= WriteEnable;
              mem_din_q <= req_wdata;
            end else begin
              state_q   <= RD;
              mem_RDn_q <= ReadEnable;
            end
          end
        end
        RD: begin
          mem_RDn_q <= ReadDisable;
          if (!we_q) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= ld_data;
            resp_err_q   <= 1'b0;
          end else begin
            state_q   <= WR;
            mem_WRn_q <= WriteEnable;
            mem_din_q <= st_word;
          end
        end
        WR: begin
          mem_WRn_q    <= WriteDisable;
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= 1'b0;
          req_ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign mem_WRn    = mem_WRn_q;
  assign mem_RDn    = mem_RDn_q;

endmodule
